// File: rtl/seq_mul_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
// Companion to seq_mul8; no configuration macros here.
package seq_mul_pkg;

    localparam int MUL_WIDTH = 8;
    localparam int MUL_PW    = 2 * MUL_WIDTH;
    localparam int CW        = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/adder.sv
// Plain 16-bit adder shared by the multiplier datapath.
// Carry-out is not produced; callers guarantee it cannot occur.
module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);

    assign s = a + b;

endmodule

// File: rtl/seq_mul8.sv
// Shift-and-add unsigned multiplier, one partial product per clock, start/busy/done handshake.
// Build option: SEQ_MUL_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start, p holds the last product
// RUN   | one conditional add per edge, WIDTH edges (fewer with early exit)
// DONE  | done pulse for one cycle, p valid, back to IDLE
module seq_mul8
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    if (2 * WIDTH != MUL_PW) begin : g_width_check
        $error("seq_mul8: 2*WIDTH must match the 16-bit adder width");
    end

    mul_state_e          state_q;
    logic [MUL_PW-1:0]   acc_q;
    logic [MUL_PW-1:0]   mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [CW-1:0]       cnt_q;
    logic [MUL_PW-1:0]   p_q;

    logic [MUL_PW-1:0]   sum;
    logic [MUL_PW-1:0]   acc_d;
    logic                last_d;

    adder u_adder (
        .a (acc_q),
        .b (mcand_q),
        .s (sum)
    );

    always_comb begin
        acc_d  = mplier_q[0] ? sum : acc_q;
        last_d = (cnt_q == CW'(WIDTH - 1));
`ifdef SEQ_MUL_EARLY_EXIT_EN
        // Nothing left to add once the shifted multiplier is empty.
        if (mplier_q[WIDTH-1:1] == '0) begin
            last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {{(MUL_PW - WIDTH){1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        p_q     <= acc_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mul8.sv
// Directed bench for seq_mul8: products, latency, handshake, back-to-back and async reset.
// Expected latencies cover both builds of SEQ_MUL_EARLY_EXIT_EN.
module tb_seq_mul8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] prev_p;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    seq_mul8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts posedges until done is seen (sampled 1 after the edge), bounded.
    task automatic wait_done(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic do_mul(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                          input logic [15:0] ep, input int lat_plain, input int lat_ee);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_p_held"}, p, prev_p);
        wait_done(n, seen);
        chk({tag, "_lat"}, n, EE ? lat_ee : lat_plain);
        chk({tag, "_p"}, p, ep);
        chk({tag, "_busy_done"}, busy, 1);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_p_keep"}, p, ep);
        prev_p = ep;
    endtask

    initial begin
        int  n;
        bit  seen;
        int  seen_cnt;

        start  = 1'b0;
        a      = '0;
        b      = '0;
        rst_n  = 1'b0;
        prev_p = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_p", p, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul("t1", 8'd13, 8'd11, 16'h008F, 8, 4);
        do_mul("t2", 8'hFF, 8'hFF, 16'hFE01, 8, 8);

        // start held high; operand change mid-run must be ignored
        @(negedge clk);
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd5;
        @(posedge clk);
        #1;
        @(negedge clk);
        a = 8'd7;
        b = 8'd9;
        wait_done(n, seen);
        chk("t3_lat1", n, EE ? 3 : 8);
        chk("t3_p1", p, 15);
        @(posedge clk);
        #1;
        chk("t3_gap_busy", busy, 0);
        chk("t3_gap_done", done, 0);
        wait_done(n, seen);
        chk("t3_lat2", n, EE ? 5 : 9);
        chk("t3_p2", p, 63);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_idle", busy, 0);
        prev_p = 16'd63;

        // async reset during RUN cycle 4
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_p", p, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_cnt++;
        end
        chk("t4_no_done", seen_cnt, 0);
        chk("t4_idle", busy, 0);
        prev_p = '0;

        do_mul("t5", 8'hAA, 8'h00, 16'h0000, 8, 1);
        do_mul("t6a", 8'h80, 8'h01, 16'h0080, 8, 1);
        do_mul("t6b", 8'h80, 8'h80, 16'h4000, 8, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
